// File: rtl/id_pkg.sv
// id_pkg: decode constants, control bundle and the
// opcode/funct to control mapping shared by the ID stage.
package id_pkg;

   localparam logic [5:0] OP_R    = 6'd0;
   localparam logic [5:0] OP_J    = 6'd2;
   localparam logic [5:0] OP_BEQ  = 6'd4;
   localparam logic [5:0] OP_BNE  = 6'd5;
   localparam logic [5:0] OP_ADDI = 6'd8;
   localparam logic [5:0] OP_LW   = 6'd35;
   localparam logic [5:0] OP_SW   = 6'd43;

   localparam logic [5:0] FN_ADD  = 6'd32;
   localparam logic [5:0] FN_SUB  = 6'd34;
   localparam logic [5:0] FN_AND  = 6'd36;
   localparam logic [5:0] FN_OR   = 6'd37;
   localparam logic [5:0] FN_SLT  = 6'd42;
   localparam logic [5:0] FN_JR   = 6'd8;

   typedef struct packed {
      logic reg_write;
      logic mem_read;
      logic mem_write;
      logic mem_to_reg;
      logic alu_src;
      logic reg_dst;
   } ctrl_t;

   localparam ctrl_t CTRL_BUBBLE = '0;

   // Branches, jumps, jr and unknown encodings carry no
   // control into EX; only real datapath ops set bits.
   function automatic ctrl_t decode(
      input logic [5:0] op,
      input logic [5:0] fn
   );
      ctrl_t c;
      logic  alu;
      alu = (fn == FN_ADD) || (fn == FN_SUB) ||
            (fn == FN_AND) || (fn == FN_OR)  ||
            (fn == FN_SLT);
      c = CTRL_BUBBLE;
      unique case (1'b1)
         (op == OP_R) && alu: begin
            c.reg_write = 1'b1;
            c.reg_dst   = 1'b1;
         end
         (op == OP_ADDI): begin
            c.reg_write = 1'b1;
            c.alu_src   = 1'b1;
         end
         (op == OP_LW): begin
            c.reg_write  = 1'b1;
            c.mem_read   = 1'b1;
            c.mem_to_reg = 1'b1;
            c.alu_src    = 1'b1;
         end
         (op == OP_SW): begin
            c.mem_write = 1'b1;
            c.alu_src   = 1'b1;
         end
         default: c = CTRL_BUBBLE;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/id_register_file.sv
// id_register_file: 2R/1W register file, r0 hardwired
// to zero, write-to-read bypass in the same cycle.
module id_register_file #(
   parameter int NUM_REGS = 32
) (
   input  logic        Clk,
   input  logic        Reset,
   input  logic        i_we,
   input  logic [4:0]  i_wa,
   input  logic [31:0] i_wd,
   input  logic [4:0]  i_ra1,
   input  logic [4:0]  i_ra2,
   output logic [31:0] o_rd1,
   output logic [31:0] o_rd2
);

   localparam int AW = $clog2(NUM_REGS);

   logic [31:0] r_mem [NUM_REGS];

   // Storage: cleared on reset, r0 never written.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         for (int i = 0; i < NUM_REGS; i++)
            r_mem[i] <= '0;
      end else if (i_we && (i_wa != 5'd0)) begin
         r_mem[i_wa[AW-1:0]] <= i_wd;
      end
   end

   assign o_rd1 = (i_ra1 == 5'd0)             ? '0   :
                  (i_we && (i_wa == i_ra1))   ? i_wd :
                  r_mem[i_ra1[AW-1:0]];

   assign o_rd2 = (i_ra2 == 5'd0)             ? '0   :
                  (i_we && (i_wa == i_ra2))   ? i_wd :
                  r_mem[i_ra2[AW-1:0]];

endmodule

// File: rtl/id_stage_v2.sv
// id_stage_v2: decode, hazard detection, early branch
// resolution and the ID/EX pipeline register.
import id_pkg::*;

module id_stage_v2 #(
   parameter int          NUM_REGS       = 32,
   parameter logic [31:0] RESET_PC_PLUS4 = 32'h0000_0004
) (
   input  logic        Clk,
   input  logic        Reset,
   input  logic [31:0] iPCPlus4,
   input  logic [31:0] iInstruction,
   input  logic        iWBRegWrite,
   input  logic [4:0]  iWBWriteReg,
   input  logic [31:0] iWBWriteData,
   input  logic        iMEMRegWrite,
   input  logic [4:0]  iMEMWriteReg,
   output logic        cPCSrc,
   output logic        cPCMux,
   output logic [31:0] PCSumImm,
   output logic [31:0] ReadReg1,
   output logic        oStall,
   output logic        oFlush,
   output logic        oRegWrite,
   output logic        oMemRead,
   output logic        oMemWrite,
   output logic        oMemToReg,
   output logic        oALUSrc,
   output logic        oRegDst,
   output logic [5:0]  oOpcode,
   output logic [5:0]  oFunct,
   output logic [31:0] oReadData1,
   output logic [31:0] oReadData2,
   output logic [31:0] oImm,
   output logic [4:0]  oRs,
   output logic [4:0]  oRt,
   output logic [4:0]  oWriteReg,
   output logic [31:0] oPCPlus4
);

   logic [5:0]  w_op, w_fn;
   logic [4:0]  w_rs, w_rt, w_rd;
   logic [31:0] w_imm, w_rd1, w_rd2;
   logic [31:0] w_btgt, w_jtgt;
   ctrl_t       w_ctrl;
   logic        w_is_beq, w_is_bne, w_is_j, w_is_jr;
   logic        w_is_br, w_use_rt, w_eq, w_take;
   logic        w_lu_haz, w_br_rs, w_br_rt, w_br_haz;
   logic        w_stall;

   ctrl_t       r_ctrl;
   logic [5:0]  r_op, r_fn;
   logic [31:0] r_rd1, r_rd2, r_imm, r_pc4;
   logic [4:0]  r_rs, r_rt, r_wr;

   id_register_file #(.NUM_REGS(NUM_REGS)) u_rf (
      .Clk   (Clk),
      .Reset (Reset),
      .i_we  (iWBRegWrite),
      .i_wa  (iWBWriteReg),
      .i_wd  (iWBWriteData),
      .i_ra1 (w_rs),
      .i_ra2 (w_rt),
      .o_rd1 (w_rd1),
      .o_rd2 (w_rd2)
   );

   assign w_op  = iInstruction[31:26];
   assign w_rs  = iInstruction[25:21];
   assign w_rt  = iInstruction[20:16];
   assign w_rd  = iInstruction[15:11];
   assign w_fn  = iInstruction[5:0];
   assign w_imm = {{16{iInstruction[15]}},
                   iInstruction[15:0]};

   assign w_ctrl   = decode(w_op, w_fn);
   assign w_is_beq = (w_op == OP_BEQ);
   assign w_is_bne = (w_op == OP_BNE);
   assign w_is_j   = (w_op == OP_J);
   assign w_is_jr  = (w_op == OP_R) && (w_fn == FN_JR);
   assign w_is_br  = w_is_beq | w_is_bne | w_is_jr;
   assign w_use_rt = (w_op == OP_R) | w_is_beq |
                     w_is_bne | (w_op == OP_SW);

   // rs is always a source; rt only where it is read.
   assign w_lu_haz = r_ctrl.mem_read && (r_wr != 5'd0) &&
                     ((w_rs == r_wr) ||
                      (w_use_rt && (w_rt == r_wr)));

   // Compare in ID needs final values, so any producer
   // still in EX or MEM holds the branch.
   assign w_br_rs = (w_rs != 5'd0) &&
      ((r_ctrl.reg_write && (w_rs == r_wr)) ||
       (iMEMRegWrite && (w_rs == iMEMWriteReg)));
   assign w_br_rt = w_use_rt && (w_rt != 5'd0) &&
      ((r_ctrl.reg_write && (w_rt == r_wr)) ||
       (iMEMRegWrite && (w_rt == iMEMWriteReg)));
   assign w_br_haz = w_is_br && (w_br_rs || w_br_rt);
   assign w_stall  = w_lu_haz || w_br_haz;

   assign w_eq   = (w_rd1 == w_rd2);
   assign w_take = (w_is_beq && w_eq) ||
                   (w_is_bne && !w_eq) || w_is_j;

   assign w_btgt = iPCPlus4 + {w_imm[29:0], 2'b00};
   assign w_jtgt = {iPCPlus4[31:28],
                    iInstruction[25:0], 2'b00};

   assign cPCSrc   = !w_stall && w_take;
   assign cPCMux   = !w_stall && w_is_jr;
   assign oFlush   = cPCSrc || cPCMux;
   assign oStall   = w_stall;
   assign PCSumImm = w_is_j ? w_jtgt : w_btgt;
   assign ReadReg1 = w_rd1;

   // ID/EX register: bubble while stalled, else decode.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         r_ctrl <= CTRL_BUBBLE;
         r_op   <= '0;
         r_fn   <= '0;
         r_rd1  <= '0;
         r_rd2  <= '0;
         r_imm  <= '0;
         r_rs   <= '0;
         r_rt   <= '0;
         r_wr   <= '0;
         r_pc4  <= RESET_PC_PLUS4;
      end else begin
         r_pc4 <= iPCPlus4;
         if (w_stall) begin
            r_ctrl <= CTRL_BUBBLE;
            r_op   <= '0;
            r_fn   <= '0;
            r_rd1  <= '0;
            r_rd2  <= '0;
            r_imm  <= '0;
            r_rs   <= '0;
            r_rt   <= '0;
            r_wr   <= '0;
         end else begin
            r_ctrl <= w_ctrl;
            r_op   <= w_op;
            r_fn   <= w_fn;
            r_rd1  <= w_rd1;
            r_rd2  <= w_rd2;
            r_imm  <= w_imm;
            r_rs   <= w_rs;
            r_rt   <= w_rt;
            r_wr   <= w_ctrl.reg_dst ? w_rd : w_rt;
         end
      end
   end

   assign oRegWrite  = r_ctrl.reg_write;
   assign oMemRead   = r_ctrl.mem_read;
   assign oMemWrite  = r_ctrl.mem_write;
   assign oMemToReg  = r_ctrl.mem_to_reg;
   assign oALUSrc    = r_ctrl.alu_src;
   assign oRegDst    = r_ctrl.reg_dst;
   assign oOpcode    = r_op;
   assign oFunct     = r_fn;
   assign oReadData1 = r_rd1;
   assign oReadData2 = r_rd2;
   assign oImm       = r_imm;
   assign oRs        = r_rs;
   assign oRt        = r_rt;
   assign oWriteReg  = r_wr;
   assign oPCPlus4   = r_pc4;

endmodule

// File: tb/tb_id_stage_v2.sv
// tb_id_stage_v2: directed tables, corner sequences and
// random instruction streams against a reference model.
module tb_id_stage_v2;

   logic        Clk = 1'b0;
   logic        Reset;
   logic [31:0] iPCPlus4, iInstruction;
   logic        iWBRegWrite, iMEMRegWrite;
   logic [4:0]  iWBWriteReg, iMEMWriteReg;
   logic [31:0] iWBWriteData;
   logic        cPCSrc, cPCMux, oStall, oFlush;
   logic [31:0] PCSumImm, ReadReg1;
   logic        oRegWrite, oMemRead, oMemWrite;
   logic        oMemToReg, oALUSrc, oRegDst;
   logic [5:0]  oOpcode, oFunct;
   logic [31:0] oReadData1, oReadData2, oImm, oPCPlus4;
   logic [4:0]  oRs, oRt, oWriteReg;

   id_stage_v2 dut (
      .Clk(Clk), .Reset(Reset),
      .iPCPlus4(iPCPlus4), .iInstruction(iInstruction),
      .iWBRegWrite(iWBRegWrite), .iWBWriteReg(iWBWriteReg),
      .iWBWriteData(iWBWriteData),
      .iMEMRegWrite(iMEMRegWrite),
      .iMEMWriteReg(iMEMWriteReg),
      .cPCSrc(cPCSrc), .cPCMux(cPCMux),
      .PCSumImm(PCSumImm), .ReadReg1(ReadReg1),
      .oStall(oStall), .oFlush(oFlush),
      .oRegWrite(oRegWrite), .oMemRead(oMemRead),
      .oMemWrite(oMemWrite), .oMemToReg(oMemToReg),
      .oALUSrc(oALUSrc), .oRegDst(oRegDst),
      .oOpcode(oOpcode), .oFunct(oFunct),
      .oReadData1(oReadData1), .oReadData2(oReadData2),
      .oImm(oImm), .oRs(oRs), .oRt(oRt),
      .oWriteReg(oWriteReg), .oPCPlus4(oPCPlus4)
   );

   always #5 Clk = ~Clk;

   int ntests = 0;
   int nfail  = 0;

   logic [31:0] m_regs [32];
   logic [5:0]  me_c;
   logic [5:0]  me_op, me_fn;
   logic [31:0] me_rd1, me_rd2, me_imm, me_pc4;
   logic [4:0]  me_rs, me_rt, me_wr;
   logic        me_bub;

   logic        s_stall, s_src, s_mux, s_flush;
   logic [31:0] s_tgt, s_rr1;

   localparam logic [31:0] NOP = 32'h0;

   typedef struct {
      logic [31:0] ins;
      logic [31:0] pc4;
      logic        src;
      logic        mux;
      logic        flush;
      logic        ck_tgt;
      logic [31:0] tgt;
      logic [31:0] rr1;
   } vec_t;

   vec_t vt [9];

   task automatic chk(input string nm,
                      input logic [31:0] act,
                      input logic [31:0] exp);
      ntests++;
      if (act !== exp) begin
         nfail++;
         $display("FAIL %s: got %h expected %h",
                  nm, act, exp);
      end
   endtask

   function automatic logic [31:0] fR(int rs, int rt,
                                      int rd, int fn);
      return {6'd0, 5'(rs), 5'(rt), 5'(rd), 5'd0, 6'(fn)};
   endfunction

   function automatic logic [31:0] fI(int op, int rs,
                                      int rt, int imm);
      return {6'(op), 5'(rs), 5'(rt), 16'(imm)};
   endfunction

   function automatic logic [31:0] fJ(int idx);
      return {6'd2, 26'(idx)};
   endfunction

   // Architectural read as seen from ID this cycle.
   function automatic logic [31:0] mrd(logic [4:0] a);
      if (a == 0) return 32'h0;
      if (iWBRegWrite && iWBWriteReg == a)
         return iWBWriteData;
      return m_regs[a];
   endfunction

   // {RegWrite,MemRead,MemWrite,MemToReg,ALUSrc,RegDst}
   function automatic logic [5:0] mctl(logic [5:0] op,
                                       logic [5:0] fn);
      case (op)
         6'd0: begin
            if (fn == 32 || fn == 34 || fn == 36 ||
                fn == 37 || fn == 42)
               return 6'b100001;
            return 6'b000000;
         end
         6'd8:  return 6'b100010;
         6'd35: return 6'b110110;
         6'd43: return 6'b001010;
         default: return 6'b000000;
      endcase
   endfunction

   task automatic chk_ex();
      chk("ex_ctrl", {oRegWrite, oMemRead, oMemWrite,
                      oMemToReg, oALUSrc, oRegDst}, me_c);
      chk("ex_rs", oRs, me_rs);
      chk("ex_rt", oRt, me_rt);
      chk("ex_wr", oWriteReg, me_wr);
      if (!me_bub) begin
         chk("ex_op", oOpcode, me_op);
         chk("ex_fn", oFunct, me_fn);
         chk("ex_rd1", oReadData1, me_rd1);
         chk("ex_rd2", oReadData2, me_rd2);
         chk("ex_imm", oImm, me_imm);
         chk("ex_pc4", oPCPlus4, me_pc4);
      end
   endtask

   // One ID cycle: drive at negedge, check combinational
   // outputs, clock, check ID/EX; returns at next negedge.
   task automatic cyc(input logic [31:0] ins,
                      input logic [31:0] pc4,
                      input logic we,
                      input logic [4:0] wa,
                      input logic [31:0] wd,
                      input logic mwe,
                      input logic [4:0] mwa);
      logic [5:0]  op, fn;
      logic [4:0]  rs, rt, rd;
      logic [31:0] a, b, imm;
      logic [4:0]  srcs[$];
      logic        lu, bh, st, isbr, src, mux;
      Reset = 1'b0;
      iInstruction = ins; iPCPlus4 = pc4;
      iWBRegWrite = we; iWBWriteReg = wa;
      iWBWriteData = wd;
      iMEMRegWrite = mwe; iMEMWriteReg = mwa;
      #1;
      op = ins[31:26]; fn = ins[5:0];
      rs = ins[25:21]; rt = ins[20:16]; rd = ins[15:11];
      imm = 32'(signed'(ins[15:0]));
      a = mrd(rs); b = mrd(rt);
      srcs = {};
      srcs.push_back(rs);
      if (op == 0 || op == 4 || op == 5 || op == 43)
         srcs.push_back(rt);
      isbr = (op == 4) || (op == 5) || (op == 0 && fn == 8);
      lu = 1'b0; bh = 1'b0;
      foreach (srcs[k]) begin
         if (me_c[4] && me_wr != 0 && srcs[k] == me_wr)
            lu = 1'b1;
         if (isbr && srcs[k] != 0 &&
             ((me_c[5] && srcs[k] == me_wr) ||
              (mwe && srcs[k] == mwa)))
            bh = 1'b1;
      end
      st  = lu | bh;
      src = !st && ((op == 4 && a == b) ||
                    (op == 5 && a != b) || op == 2);
      mux = !st && op == 0 && fn == 8;
      s_stall = oStall; s_src = cPCSrc; s_mux = cPCMux;
      s_flush = oFlush; s_tgt = PCSumImm; s_rr1 = ReadReg1;
      chk("stall", oStall, st);
      chk("pcsrc", cPCSrc, src);
      chk("pcmux", cPCMux, mux);
      chk("flush", oFlush, src | mux);
      chk("readreg1", ReadReg1, a);
      if (op == 2)
         chk("jtgt", PCSumImm,
             {pc4[31:28], ins[25:0], 2'b00});
      else if (op == 4 || op == 5)
         chk("btgt", PCSumImm, pc4 + imm * 4);
      if (st) begin
         me_c = '0; me_rs = '0; me_rt = '0; me_wr = '0;
         me_bub = 1'b1;
      end else begin
         me_c = mctl(op, fn);
         me_op = op; me_fn = fn; me_rd1 = a; me_rd2 = b;
         me_imm = imm; me_rs = rs; me_rt = rt;
         me_wr = me_c[0] ? rd : rt;
         me_pc4 = pc4; me_bub = 1'b0;
      end
      @(posedge Clk);
      if (we && wa != 0) m_regs[wa] = wd;
      #1;
      chk_ex();
      @(negedge Clk);
   endtask

   task automatic do_reset();
      Reset = 1'b1;
      iWBRegWrite = 1'b0; iWBWriteReg = '0;
      iWBWriteData = '0;
      iMEMRegWrite = 1'b0; iMEMWriteReg = '0;
      #1;
      foreach (m_regs[i]) m_regs[i] = '0;
      me_c = '0; me_op = '0; me_fn = '0; me_rd1 = '0;
      me_rd2 = '0; me_imm = '0; me_rs = '0; me_rt = '0;
      me_wr = '0; me_pc4 = 32'h4; me_bub = 1'b0;
      chk_ex();
      chk("rst_stall", oStall, 0);
      chk("rst_flush", oFlush, 0);
      chk("rst_rf", ReadReg1, 0);
      @(posedge Clk);
      #1;
      chk_ex();
      @(negedge Clk);
      Reset = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      logic [31:0] ins;
      int k, rs, rt, rd;
      int fns [5];
      fns = '{32, 34, 36, 37, 42};

      iInstruction = fR(2, 3, 4, 32);
      iPCPlus4 = 32'h8;
      do_reset();

      cyc(NOP, 32'h8, 1, 5, 32'd7, 0, 0);
      cyc(fR(5, 0, 3, 32), 32'hC, 0, 0, 0, 0, 0);
      chk("rf_r5", oReadData1, 32'd7);

      cyc(fR(8, 0, 3, 32), 32'h10, 1, 8, 32'h1234, 0, 0);
      chk("bypass", oReadData1, 32'h1234);
      cyc(fR(0, 0, 3, 32), 32'h14, 1, 0, 32'hFFFF, 0, 0);
      chk("r0_wb", oReadData1, 32'h0);
      cyc(fR(0, 0, 3, 32), 32'h18, 0, 0, 0, 0, 0);
      chk("r0_zero", oReadData1, 32'h0);

      cyc(fI(35, 1, 2, 0), 32'h20, 0, 0, 0, 0, 0);
      cyc(fR(2, 3, 4, 32), 32'h24, 0, 0, 0, 0, 0);
      chk("lu_stall", s_stall, 1);
      chk("lu_bubble", oRegWrite, 0);
      chk("lu_bub_rs", oRs, 0);
      cyc(fR(2, 3, 4, 32), 32'h24, 0, 0, 0, 0, 0);
      chk("lu_clear", s_stall, 0);
      chk("lu_rs", oRs, 2);
      chk("lu_wr", oWriteReg, 4);

      cyc(NOP, 32'h30, 1, 1, 32'h11, 0, 0);
      cyc(NOP, 32'h34, 1, 31, 32'h40, 0, 0);
      cyc(NOP, 32'h38, 0, 0, 0, 0, 0);

      vt[0] = '{fI(4, 1, 1, 3), 32'h104,
                1, 0, 1, 1, 32'h110, 32'h11};
      vt[1] = '{fI(5, 1, 1, 3), 32'h104,
                0, 0, 0, 1, 32'h110, 32'h11};
      vt[2] = '{fI(5, 1, 0, -1), 32'h200,
                1, 0, 1, 1, 32'h1FC, 32'h11};
      vt[3] = '{fI(4, 1, 2, 5), 32'h1000,
                0, 0, 0, 1, 32'h1014, 32'h11};
      vt[4] = '{fJ(32'h10), 32'hA000_0004,
                1, 0, 1, 1, 32'hA000_0040, 32'h0};
      vt[5] = '{fR(31, 0, 0, 8), 32'h300,
                0, 1, 1, 0, 32'h0, 32'h40};
      vt[6] = '{32'hFC00_0000, 32'h40,
                0, 0, 0, 0, 32'h0, 32'h0};
      vt[7] = '{fI(8, 1, 6, 5), 32'h44,
                0, 0, 0, 0, 32'h0, 32'h11};
      vt[8] = '{fI(4, 0, 0, -2), 32'h4,
                1, 0, 1, 1, 32'hFFFF_FFFC, 32'h0};

      for (int i = 0; i < 9; i++) begin
         cyc(vt[i].ins, vt[i].pc4, 0, 0, 0, 0, 0);
         chk($sformatf("v%0d_stall", i), s_stall, 0);
         chk($sformatf("v%0d_src", i), s_src, vt[i].src);
         chk($sformatf("v%0d_mux", i), s_mux, vt[i].mux);
         chk($sformatf("v%0d_flush", i), s_flush,
             vt[i].flush);
         chk($sformatf("v%0d_rr1", i), s_rr1, vt[i].rr1);
         if (vt[i].ck_tgt)
            chk($sformatf("v%0d_tgt", i), s_tgt, vt[i].tgt);
         cyc(NOP, 32'h0, 0, 0, 0, 0, 0);
      end
      cyc(32'hFC00_0000, 32'h48, 0, 0, 0, 0, 0);
      chk("undef_rw", oRegWrite, 0);
      chk("undef_mr", oMemRead, 0);

      cyc(fI(8, 0, 9, 5), 32'h50, 0, 0, 0, 0, 0);
      cyc(fI(4, 9, 0, 1), 32'h54, 0, 0, 0, 0, 0);
      chk("bh_ex", s_stall, 1);
      cyc(fI(4, 9, 0, 1), 32'h54, 0, 0, 0, 1, 9);
      chk("bh_mem", s_stall, 1);
      cyc(fI(4, 9, 0, 1), 32'h54, 1, 9, 32'd5, 0, 0);
      chk("bh_done", s_stall, 0);
      chk("bh_ntkn", s_src, 0);
      chk("bh_nfl", s_flush, 0);

      for (int n = 0; n < 400; n++) begin
         k  = $urandom_range(0, 12);
         rs = $urandom_range(0, 7);
         rt = $urandom_range(0, 7);
         rd = $urandom_range(0, 7);
         case (k)
            0, 1, 2, 3, 4: ins = fR(rs, rt, rd, fns[k]);
            5:  ins = fR(rs, 0, 0, 8);
            6:  ins = fI(8, rs, rt, $urandom);
            7:  ins = fI(35, rs, rt, $urandom);
            8:  ins = fI(43, rs, rt, $urandom);
            9:  ins = fI(4, rs, rt, $urandom);
            10: ins = fI(5, rs, rt, $urandom);
            11: ins = fJ($urandom);
            default: ins = $urandom;
         endcase
         cyc(ins, $urandom & 32'hFFFF_FFFC,
             1'($urandom_range(0, 1)),
             5'($urandom_range(0, 7)), $urandom,
             1'($urandom_range(0, 1)),
             5'($urandom_range(0, 7)));
      end

      cyc(NOP, 32'h60, 1, 1, 32'h11, 0, 0);
      cyc(fI(35, 1, 2, 0), 32'h64, 0, 0, 0, 0, 0);
      iInstruction = fR(2, 3, 4, 32);
      #1;
      chk("pre_rst_stall", oStall, 1);
      do_reset();
      cyc(fR(1, 0, 3, 32), 32'h70, 0, 0, 0, 0, 0);
      chk("rst_r1", oReadData1, 0);

      $display("[TB] %0d tests run, %0d failed",
               ntests, nfail);
      $finish;
   end

endmodule
